// File: rtl/dcache_pkg.sv
// Shared types and address-split width helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} state_e;

  function automatic int off_w(input int data_w, input int line_words);
    return $clog2(data_w / 8) + $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w, input int line_words,
                               input int sets);
    return addr_w - off_w(data_w, line_words) - idx_w(sets);
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Tag/valid/dirty state plus line data; byte-lane write port, asynchronous read port.
module dcache_store #(
  parameter  int DATA_W     = 32,
  parameter  int LINE_WORDS = 4,
  parameter  int SETS       = 16,
  parameter  int TAG_W      = 24,
  localparam int NB         = DATA_W / 8,
  localparam int IDX_W      = $clog2(SETS),
  localparam int WORD_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] rd_word_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  input  logic              wr_en_i,
  input  logic [WORD_W-1:0] wr_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [NB-1:0]     wr_be_i,
  input  logic              meta_we_i,
  input  logic              meta_valid_i,
  input  logic              meta_dirty_i,
  input  logic [TAG_W-1:0]  meta_tag_i
);

  logic [SETS-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS*LINE_WORDS];

  assign rd_data_o  = data_q[{idx_i, rd_word_i}];
  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we_i) begin
      valid_q[idx_i] <= meta_valid_i;
      dirty_q[idx_i] <= meta_dirty_i;
    end
  end

  // Tags and data only matter behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (meta_we_i) tag_q[idx_i] <= meta_tag_i;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_en_i && wr_be_i[b]) data_q[{idx_i, wr_word_i}][b*8 +: 8] <= wr_data_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with burst memory port.
// Optional DCACHE_EARLY_RESTART_EN releases a load on the refill beat carrying its word.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addy,
  input  logic [DATA_W-1:0]   datain,
  input  logic                wen,
  input  logic                ren,
  input  logic [DATA_W/8-1:0] byte_select_vector,
  output logic                nostall,
  output logic [DATA_W-1:0]   dataout,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB     = DATA_W / 8;
  localparam int BYTE_W = $clog2(NB);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = off_w(DATA_W, LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, DATA_W, LINE_WORDS, SETS);
  localparam logic [WORD_W-1:0] LAST = WORD_W'(LINE_WORDS - 1);

  state_e              state_q;
  logic [WORD_W-1:0]   beat_q, word_q;
  logic [IDX_W-1:0]    idx_q;
  logic [TAG_W-1:0]    vtag_q, rtag_q;
  logic                load_q, mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   dout_q;

  logic [TAG_W-1:0]    a_tag;
  logic [IDX_W-1:0]    a_idx;
  logic [WORD_W-1:0]   a_word, beat_n;
  logic                access, hit, load_hit, early, refill_ack;
  logic [IDX_W-1:0]    st_idx;
  logic [WORD_W-1:0]   rd_word, wr_word;
  logic [DATA_W-1:0]   rd_data, wr_data;
  logic                rd_valid, rd_dirty, wr_en, meta_we, meta_dirty;
  logic [TAG_W-1:0]    rd_tag, meta_tag;
  logic [NB-1:0]       wr_be;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [WORD_W-1:0] w);
    return {t, i, w, {BYTE_W{1'b0}}};
  endfunction

  assign a_tag  = addy[ADDR_W-1 -: TAG_W];
  assign a_idx  = addy[OFF_W +: IDX_W];
  assign a_word = addy[BYTE_W +: WORD_W];
  assign beat_n = beat_q + 1'b1;

  // While a miss is in flight the latched index addresses the store, not addy.
  assign st_idx  = (state_q == IDLE) ? a_idx : idx_q;
  assign rd_word = (state_q == WB) ? beat_q : a_word;

  assign access     = ren || wen;
  assign hit        = access && rd_valid && (rd_tag == a_tag);
  assign load_hit   = (state_q == IDLE) && ren && !wen && hit;
  assign refill_ack = (state_q == REFILL) && mem_ack;

`ifdef DCACHE_EARLY_RESTART_EN
  assign early = refill_ack && load_q && (beat_q == word_q);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    wr_en      = 1'b0;
    wr_word    = beat_q;
    wr_data    = mem_rdata;
    wr_be      = '1;
    meta_we    = 1'b0;
    meta_dirty = 1'b0;
    meta_tag   = rtag_q;
    if (state_q == IDLE && wen && hit) begin
      wr_en      = 1'b1;
      wr_word    = a_word;
      wr_data    = datain;
      wr_be      = byte_select_vector;
      meta_we    = 1'b1;
      meta_dirty = 1'b1;
      meta_tag   = a_tag;
    end else if (refill_ack) begin
      wr_en   = 1'b1;
      meta_we = (beat_q == LAST);
    end
  end

  always_comb begin
    if (!reset)                nostall = 1'b1;
    else if (state_q == IDLE)  nostall = !(access && !hit);
    else                       nostall = early;
  end

  assign dataout   = early ? mem_rdata : (load_hit ? rd_data : dout_q);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = (state_q == WB) ? rd_data : '0;

  dcache_store #(
    .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS), .TAG_W(TAG_W)
  ) u_store (
    .clk          (clk),
    .rst_n        (reset),
    .idx_i        (st_idx),
    .rd_word_i    (rd_word),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .rd_dirty_o   (rd_dirty),
    .rd_tag_o     (rd_tag),
    .wr_en_i      (wr_en),
    .wr_word_i    (wr_word),
    .wr_data_i    (wr_data),
    .wr_be_i      (wr_be),
    .meta_we_i    (meta_we),
    .meta_valid_i (1'b1),
    .meta_dirty_i (meta_dirty),
    .meta_tag_i   (meta_tag)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      vtag_q     <= '0;
      rtag_q     <= '0;
      load_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      dout_q     <= '0;
    end else begin
      if (load_hit || early) dout_q <= dataout;
      case (state_q)
        IDLE: if (access && !hit) begin
          idx_q     <= a_idx;
          vtag_q    <= rd_tag;
          rtag_q    <= a_tag;
          word_q    <= a_word;
          load_q    <= !wen;
          beat_q    <= '0;
          mem_req_q <= 1'b1;
          if (rd_valid && rd_dirty) begin
            state_q    <= WB;
            mem_we_q   <= 1'b1;
            mem_addr_q <= beat_addr(rd_tag, a_idx, '0);
          end else begin
            state_q    <= REFILL;
            mem_we_q   <= 1'b0;
            mem_addr_q <= beat_addr(a_tag, a_idx, '0);
          end
        end
        WB: if (mem_ack) begin
          if (beat_q == LAST) begin
            state_q    <= REFILL;
            beat_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= beat_addr(rtag_q, idx_q, '0);
          end else begin
            beat_q     <= beat_n;
            mem_addr_q <= beat_addr(vtag_q, idx_q, beat_n);
          end
        end
        REFILL: if (mem_ack) begin
          if (beat_q == LAST) begin
            state_q   <= DONE;
            beat_q    <= '0;
            mem_req_q <= 1'b0;
          end else begin
            beat_q     <= beat_n;
            mem_addr_q <= beat_addr(rtag_q, idx_q, beat_n);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: memory beats are checked against a scoreboard queue.
module tb_dcache_ctrl;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addy, datain, dataout, mem_addr, mem_wdata, mem_rdata;
  logic        wen, ren, nostall, mem_req, mem_we, mem_ack;
  logic [3:0]  byte_select_vector;

  int          total = 0;
  int          bad   = 0;
  int          ack_dly = 0;
  beat_t       exp_q[$];
  logic [31:0] mem [logic [31:0]];

  dcache_ctrl dut (
    .clk(clk), .reset(reset), .addy(addy), .datain(datain), .wen(wen), .ren(ren),
    .byte_select_vector(byte_select_vector), .nostall(nostall), .dataout(dataout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_w(input logic [31:0] a);
    if (a[31:8] == 24'h1) return 32'hA0 + {30'd0, a[3:2]};
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_w(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_reads(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, base + 32'(4*i), 32'h0});
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{1'b1, a, d});
  endtask

  // Memory responder: acks after ack_dly waiting cycles and scores every accepted beat.
  int          wcnt = 0;
  bit          waiting = 0;
  logic [31:0] prev_addr;
  logic        prev_we;
  always @(posedge clk) begin
    #1;
    if (!reset || !mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
      waiting = 0;
    end else if (wcnt >= ack_dly) begin
      beat_t e;
      mem_ack = 1'b1;
      mem_rdata = rd_mem(mem_addr);
      chk("beat_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("beat_we", 32'(mem_we), 32'(e.we));
        chk("beat_addr", mem_addr, e.addr);
        if (e.we) chk("beat_wdata", mem_wdata, e.wdata);
      end
      if (mem_we) mem[mem_addr] = mem_wdata;
      wcnt    = 0;
      waiting = 0;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (waiting) begin
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_we", 32'(mem_we), 32'(prev_we));
      end
      prev_addr = mem_addr;
      prev_we   = mem_we;
      waiting   = 1;
      wcnt++;
    end
  end

  // Called at a negedge; holds the request until nostall, returns at the next negedge.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                        input logic [3:0] be, output int stalls, output logic [31:0] dout);
    addy = a; datain = d; wen = w; ren = r; byte_select_vector = be;
    stalls = 0;
    #1;
    while (!nostall && stalls < 200) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (!nostall) chk("access_timeout", 32'(nostall), 32'd1);
    dout = dataout;
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
  endtask

  initial begin
    int          st;
    logic [31:0] d;
    mem_ack = 1'b0; mem_rdata = '0;
    reset = 1'b0; wen = 1'b0; ren = 1'b1; addy = 32'h100; datain = '0;
    byte_select_vector = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_nostall", 32'(nostall), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_dataout", dataout, 32'h0);
    @(negedge clk);
    ren = 1'b0; reset = 1'b1;
    @(negedge clk);

`ifdef DCACHE_EARLY_RESTART_EN
    push_reads(32'h100);
    addy = 32'h108; ren = 1'b1;
    #1 chk("er_miss", 32'(nostall), 32'd0);
    @(negedge clk); #1 chk("er_beat0", 32'(nostall), 32'd0);
    @(negedge clk); #1 chk("er_beat1", 32'(nostall), 32'd0);
    @(negedge clk); #1 chk("er_beat2_go", 32'(nostall), 32'd1);
    chk("er_data", dataout, 32'hA2);
    @(negedge clk); ren = 1'b0;
    #1 chk("er_beat3", 32'(nostall), 32'd0);
    @(negedge clk); #1 chk("er_done", 32'(nostall), 32'd0);
    @(negedge clk); #1 chk("er_idle", 32'(nostall), 32'd1);
    access(32'h10C, 32'h0, 1'b0, 1'b1, 4'h0, st, d);
    chk("er_hit_stall", st, 0);
    chk("er_hit_data", d, 32'hA3);
    chk("er_q_empty", exp_q.size(), 0);
`else
    // Cold load: four read beats, six stalled cycles.
    push_reads(32'h100);
    access(32'h100, 32'h0, 1'b0, 1'b1, 4'h0, st, d);
    chk("t1_stall", st, 6);
    chk("t1_data", d, 32'hA0);
    chk("t1_q_empty", exp_q.size(), 0);
    #1 chk("t1_dout_hold", dataout, 32'hA0);

    // Store hit on lanes 0-1, then load it back.
    access(32'h104, 32'hDEADBEEF, 1'b1, 1'b0, 4'b0011, st, d);
    chk("t2_store_stall", st, 0);
    access(32'h104, 32'h0, 1'b0, 1'b1, 4'h0, st, d);
    chk("t2_load_stall", st, 0);
    chk("t2_load_data", d, merge(32'hA1, 32'hDEADBEEF, 4'b0011));

    // Conflict miss on a dirty line: write-back then refill.
    push_write(32'h100, 32'hA0);
    push_write(32'h104, merge(32'hA1, 32'hDEADBEEF, 4'b0011));
    push_write(32'h108, 32'hA2);
    push_write(32'h10C, 32'hA3);
    push_reads(32'h200);
    access(32'h204, 32'h0, 1'b0, 1'b1, 4'h0, st, d);
    chk("t3_stall", st, 10);
    chk("t3_data", d, init_w(32'h204));
    chk("t3_q_empty", exp_q.size(), 0);
    access(32'h200, 32'h0, 1'b0, 1'b1, 4'h0, st, d);
    chk("t3_hit_stall", st, 0);
    chk("t3_hit_data", d, init_w(32'h200));

    // Store miss allocates the line, then merges the enabled lanes.
    push_reads(32'h410);
    access(32'h410, 32'h11223344, 1'b1, 1'b0, 4'b0101, st, d);
    chk("ts_stall", st, 6);
    access(32'h410, 32'h0, 1'b0, 1'b1, 4'h0, st, d);
    chk("ts_load_stall", st, 0);
    chk("ts_load_data", d, merge(init_w(32'h410), 32'h11223344, 4'b0101));
    access(32'h414, 32'h0, 1'b0, 1'b1, 4'h0, st, d);
    chk("ts_other_word", d, init_w(32'h414));

    // Slow memory: each beat waits three cycles for its ack.
    ack_dly = 3;
    push_reads(32'h300);
    access(32'h300, 32'h0, 1'b0, 1'b1, 4'h0, st, d);
    chk("t4_stall", st, 18);
    chk("t4_data", d, init_w(32'h300));
    chk("t4_q_empty", exp_q.size(), 0);
    ack_dly = 0;

    // Reset during the second refill beat abandons the burst.
    exp_q.push_back('{1'b0, 32'h100, 32'h0});
    exp_q.push_back('{1'b0, 32'h104, 32'h0});
    addy = 32'h100; ren = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_mem_req", 32'(mem_req), 32'd0);
    chk("t5_nostall", 32'(nostall), 32'd1);
    chk("t5_dataout", dataout, 32'h0);
    chk("t5_q_empty", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    push_reads(32'h100);
    access(32'h100, 32'h0, 1'b0, 1'b1, 4'h0, st, d);
    chk("t5_reload_stall", st, 6);
    chk("t5_reload_data", d, 32'hA0);
    chk("t5_reload_q_empty", exp_q.size(), 0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
